// File: rtl/arith_sched_pkg.sv
// Shared types for the arithmetic scheduler.
//   state_t      : scheduler FSM states
//   rsp_entry_t  : response FIFO entry {id, s, cout, sr}
//   MAX_NREQ     : widest requester set the scheduler supports
//   rr_index()   : round-robin candidate index, (base + k) mod nreq
package arith_sched_pkg;

   localparam int MAX_NREQ = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   typedef struct packed {
      logic [1:0] id;
      logic [2:0] s;
      logic       cout;
      logic [2:0] sr;
   } rsp_entry_t;

   function automatic logic [1:0] rr_index(logic [1:0] base, int k, int nreq);
      int sum;
      sum = int'(base) + k;
      return 2'(sum % nreq);
   endfunction

endpackage

// File: rtl/arith_rsp_fifo.sv
// Response FIFO: circular buffer of rsp_entry_t with wrapping pointers.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head_valid : FIFO holds at least one entry
//   head_data  : entry at the head
//   count      : number of stored entries, 0..DEPTH
module arith_rsp_fifo
   import arith_sched_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  rsp_entry_t push_data,
   input  logic       pop,
   output logic       head_valid,
   output rsp_entry_t head_data,
   output logic [PW:0] count
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   rsp_entry_t    mem_q [DEPTH];
   rsp_entry_t    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_valid = (count_q != '0);
   assign head_data  = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/arithmetic_ip.sv
// Shared combinational arithmetic unit.
//   a, b : 2-bit operands
//   m    : mode (0 add, 1 subtract, 2 multiply, 3 logic)
//   s    : 3-bit result
//   cout : carry / no-borrow / product overflow / any-common-bit
//   sr   : result shifted right one place through the carry, {cout, s[2:1]}
module arithmetic_ip (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic [1:0] m,
   output logic [2:0] s,
   output logic       cout,
   output logic [2:0] sr
);

   logic [3:0] prod;

   always_comb begin
      s    = '0;
      cout = 1'b0;
      prod = {2'b00, a} * {2'b00, b};
      case (m)
         2'd0: begin
            s    = {1'b0, a} + {1'b0, b};
            cout = s[2];
         end
         2'd1: begin
            // 3-bit two's complement difference; cout set when no borrow
            s    = {1'b0, a} - {1'b0, b};
            cout = (a >= b);
         end
         2'd2: begin
            s    = prod[2:0];
            cout = prod[3];
         end
         default: begin
            s    = {^{a, b}, a ^ b};
            cout = |(a & b);
         end
      endcase
   end

   assign sr = {cout, s[2:1]};

endmodule

// File: rtl/arith_sched.sv
// Round-robin scheduler sharing one arithmetic_ip between NREQ requesters.
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready         : per-requester handshake (ready one-hot or zero)
//   req_a/req_b/req_mode        : packed 2-bit operands, requester i in [2i+1:2i]
//   rsp_valid/rsp_ready         : response FIFO head handshake
//   rsp_id/rsp_s/rsp_cout/rsp_sr: head entry fields
//   busy                        : high while an operation is in ISSUE
//   op_count                    : completed operations, saturating
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | arbitrate; accept one request if the FIFO has a free slot
// ST_ISSUE | operand register drives the unit; result pushed at cycle end
module arith_sched
   import arith_sched_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [2*NREQ-1:0] req_a,
   input  logic [2*NREQ-1:0] req_b,
   input  logic [2*NREQ-1:0] req_mode,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_id,
   output logic [2:0]        rsp_s,
   output logic              rsp_cout,
   output logic [2:0]        rsp_sr,
   output logic              busy,
   output logic [15:0]       op_count
);

   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   state_t      state_q, state_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]  op_a_q, op_a_d;
   logic [1:0]  op_b_q, op_b_d;
   logic [1:0]  op_mode_q, op_mode_d;
   logic [1:0]  op_id_q, op_id_d;
   logic [15:0] op_count_q, op_count_d;

   // Requests widened to MAX_NREQ so a 2-bit index is always in range
   logic [MAX_NREQ-1:0]   valid_ext;
   logic [2*MAX_NREQ-1:0] a_ext, b_ext, mode_ext;

   logic       gnt_found, grant;
   logic [1:0] gnt_id, cand;
   logic [2:0] alu_s, alu_sr;
   logic       alu_cout;
   logic       fifo_push, fifo_pop, fifo_full;
   logic [PW:0] fifo_count;
   rsp_entry_t push_data, head_data;

   assign valid_ext = MAX_NREQ'(req_valid);
   assign a_ext     = (2*MAX_NREQ)'(req_a);
   assign b_ext     = (2*MAX_NREQ)'(req_b);
   assign mode_ext  = (2*MAX_NREQ)'(req_mode);

   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = rr_index(rr_ptr_q, k, NREQ);
         if (!gnt_found && valid_ext[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   // Registered count only: a same-cycle pop never frees a slot for this grant
   assign fifo_full = (fifo_count == FULL_CNT);
   assign grant     = !rst && (state_q == ST_IDLE) && !fifo_full && gnt_found;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant && (gnt_id == 2'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_mode_d  = op_mode_q;
      op_id_d    = op_id_q;
      op_count_d = op_count_q;
      fifo_push  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               op_a_d    = a_ext[{gnt_id, 1'b0} +: 2];
               op_b_d    = b_ext[{gnt_id, 1'b0} +: 2];
               op_mode_d = mode_ext[{gnt_id, 1'b0} +: 2];
               op_id_d   = gnt_id;
               rr_ptr_d  = (int'(gnt_id) == NREQ - 1) ? 2'd0 : gnt_id + 2'd1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            fifo_push = 1'b1;
            if (op_count_q != 16'hFFFF) begin
               op_count_d = op_count_q + 16'd1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_mode_q  <= '0;
         op_id_q    <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_mode_q  <= op_mode_d;
         op_id_q    <= op_id_d;
         op_count_q <= op_count_d;
      end
   end

   arithmetic_ip u_alu (
      .a    (op_a_q),
      .b    (op_b_q),
      .m    (op_mode_q),
      .s    (alu_s),
      .cout (alu_cout),
      .sr   (alu_sr)
   );

   always_comb begin
      push_data      = '0;
      push_data.id   = op_id_q;
      push_data.s    = alu_s;
      push_data.cout = alu_cout;
      push_data.sr   = alu_sr;
   end

   assign fifo_pop = rsp_valid && rsp_ready;

   arith_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_data  (push_data),
      .pop        (fifo_pop),
      .head_valid (rsp_valid),
      .head_data  (head_data),
      .count      (fifo_count)
   );

   assign rsp_id   = head_data.id;
   assign rsp_s    = head_data.s;
   assign rsp_cout = head_data.cout;
   assign rsp_sr   = head_data.sr;
   assign busy     = (state_q == ST_ISSUE);
   assign op_count = op_count_q;

endmodule

// File: tb/tb_arith_sched.sv
module tb_arith_sched;

   localparam int NREQ  = 2;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [2*NREQ-1:0] req_a, req_b, req_mode;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [2:0]        rsp_s, rsp_sr;
   logic              rsp_cout;
   logic              busy;
   logic [15:0]       op_count;

   always #5 clk = ~clk;

   arith_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_mode  (req_mode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_s     (rsp_s),
      .rsp_cout  (rsp_cout),
      .rsp_sr    (rsp_sr),
      .busy      (busy),
      .op_count  (op_count)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int base  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Per-requester pending operations
   logic [1:0] pa [NREQ][16];
   logic [1:0] pb [NREQ][16];
   logic [1:0] pm [NREQ][16];
   int         hd [NREQ];
   int         tl [NREQ];

   logic [8:0] exp_q [$];
   int         gnt_id_log [$];
   int         gnt_cyc_log [$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   // Golden unit: {id, s, cout, sr}
   function automatic logic [8:0] model(int id, int a, int b, int m);
      int s, c, sr;
      case (m)
         0: begin s = a + b; c = (s >= 4) ? 1 : 0; end
         1: begin s = (a - b) & 7; c = (a >= b) ? 1 : 0; end
         2: begin s = (a * b) & 7; c = ((a * b) >= 8) ? 1 : 0; end
         default: begin
            s = (a ^ b) | ((($countones(a) + $countones(b)) & 1) << 2);
            c = ((a & b) != 0) ? 1 : 0;
         end
      endcase
      sr = (c << 2) | (s >> 1);
      return {2'(id), 3'(s), 1'(c), 3'(sr)};
   endfunction

   task automatic enq(int i, int a, int b, int m, bit expect_rsp);
      pa[i][tl[i] % 16] = 2'(a);
      pb[i][tl[i] % 16] = 2'(b);
      pm[i][tl[i] % 16] = 2'(m);
      tl[i]++;
      if (expect_rsp) exp_q.push_back(model(i, a, b, m));
   endtask

   // One clock cycle: drive queue fronts, sample handshakes at negedge
   task automatic tick();
      logic [NREQ-1:0] hs;
      for (int i = 0; i < NREQ; i++) begin
         if (hd[i] != tl[i]) begin
            req_valid[i]        = 1'b1;
            req_a[2*i +: 2]     = pa[i][hd[i] % 16];
            req_b[2*i +: 2]     = pb[i][hd[i] % 16];
            req_mode[2*i +: 2]  = pm[i][hd[i] % 16];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
      @(negedge clk);
      hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (hs[i]) begin
            gnt_id_log.push_back(i);
            gnt_cyc_log.push_back(cyc - base);
            hd[i]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(int n);
      while (cyc - base < n) tick();
   endtask

   // rst is high for relative cycles 0 and 1; returns in cycle 2
   task automatic do_reset();
      rsp_ready = 1'b0;
      rst       = 1'b1;
      base      = cyc;
      tick();
      tick();
      rst = 1'b0;
      gnt_id_log.delete();
      gnt_cyc_log.delete();
   endtask

   task automatic drain(int budget, string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got %0h, expected no response",
                     {rsp_id, rsp_s, rsp_cout, rsp_sr});
         end else begin
            e = exp_q.pop_front();
            check("rsp_entry", {rsp_id, rsp_s, rsp_cout, rsp_sr}, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_mode  = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      @(posedge clk);
      #1;

      // Single operation: reset values, latency, fields
      do_reset();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_fields", {rsp_s, rsp_cout, rsp_sr}, 0);
      check("rst_busy", busy, 0);
      check("rst_op_count", op_count, 0);
      rsp_ready = 1'b1;
      run_to(5);
      enq(0, 1, 2, 0, 1);
      tick();
      check("t1_gnt_count", gnt_id_log.size(), 1);
      if (gnt_cyc_log.size() > 0) check("t1_gnt_cycle", gnt_cyc_log[0], 5);
      check("t1_busy_c6", busy, 1);
      check("t1_no_early_valid", rsp_valid, 0);
      tick();
      check("t1_rsp_valid_c7", rsp_valid, 1);
      check("t1_rsp_id", rsp_id, 0);
      check("t1_rsp_fields", {rsp_s, rsp_cout, rsp_sr}, 7'b011_0_001);
      check("t1_op_count", op_count, 1);
      drain(20, "t1_drain");

      // Both requesters continuously valid: strict rotation
      do_reset();
      rsp_ready = 1'b1;
      run_to(5);
      enq(0, 3, 3, 0, 1);
      enq(1, 1, 3, 2, 1);
      enq(0, 2, 1, 1, 1);
      enq(1, 3, 2, 3, 1);
      run_to(13);
      check("t2_gnt_count", gnt_id_log.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < gnt_id_log.size()) begin
            check($sformatf("t2_gnt_id_%0d", k), gnt_id_log[k], k % 2);
            check($sformatf("t2_gnt_cyc_%0d", k), gnt_cyc_log[k], 5 + 2 * k);
         end
      end
      drain(20, "t2_drain");

      // Full FIFO back-pressure, grant only after a registered pop
      do_reset();
      run_to(3);
      enq(0, 0, 1, 0, 1);
      enq(1, 3, 1, 1, 1);
      enq(0, 2, 3, 2, 1);
      enq(1, 1, 2, 3, 1);
      enq(0, 3, 0, 1, 1);
      run_to(20);
      check("t3_accepted", gnt_id_log.size(), 4);
      check("t3_ready_while_full", req_ready, 0);
      check("t3_fifo_count_full", dut.u_fifo.count_q, 4);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t3_no_grant_same_cycle", gnt_id_log.size(), 4);
      tick();
      check("t3_grant_after_pop", gnt_id_log.size(), 5);
      if (gnt_cyc_log.size() > 4) check("t3_grant_cycle", gnt_cyc_log[4], 21);
      rsp_ready = 1'b1;
      drain(40, "t3_drain");

      // Simultaneous push/pop, then pointer wrap across 6 entries
      do_reset();
      run_to(3);
      enq(0, 2, 2, 0, 1);
      tick();
      run_to(5);
      enq(1, 1, 1, 1, 1);
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t4_count_push_pop", dut.u_fifo.count_q, 1);
      check("t4_head_valid", rsp_valid, 1);
      enq(0, 3, 1, 1, 1);
      enq(1, 0, 3, 1, 1);
      enq(0, 3, 2, 2, 1);
      enq(1, 2, 3, 3, 1);
      run_to(16);
      rsp_ready = 1'b1;
      drain(40, "t4_drain");
      check("t4_op_count", op_count, 6);

      // Reset during ISSUE discards the in-flight operation
      do_reset();
      rsp_ready = 1'b1;
      run_to(5);
      enq(0, 3, 3, 2, 0);
      enq(0, 1, 1, 0, 1);
      enq(1, 2, 3, 1, 1);
      tick();
      rst = 1'b1;
      tick();
      check("t5_rsp_valid_after_rst", rsp_valid, 0);
      check("t5_op_count_after_rst", op_count, 0);
      check("t5_busy_after_rst", busy, 0);
      check("t5_ready_during_rst", req_ready, 0);
      tick();
      rst = 1'b0;
      gnt_id_log.delete();
      gnt_cyc_log.delete();
      tick();
      check("t5_gnt_count", gnt_id_log.size(), 1);
      if (gnt_id_log.size() > 0) check("t5_gnt_after_rst", gnt_id_log[0], 0);
      drain(20, "t5_drain");

      // op_count saturation with a single requester every 2 cycles
      do_reset();
      rsp_ready = 1'b1;
      run_to(3);
      force dut.op_count_q = 16'hFFFE;
      tick();
      release dut.op_count_q;
      enq(0, 1, 1, 2, 1);
      enq(0, 2, 2, 2, 1);
      enq(0, 3, 3, 3, 1);
      run_to(6);
      check("t6_op_count_1", op_count, 16'hFFFF);
      run_to(8);
      check("t6_op_count_2", op_count, 16'hFFFF);
      run_to(10);
      check("t6_op_count_3", op_count, 16'hFFFF);
      check("t6_gnt_count", gnt_id_log.size(), 3);
      if (gnt_cyc_log.size() > 2) begin
         check("t6_gnt_cyc_1", gnt_cyc_log[1], 6);
         check("t6_gnt_cyc_2", gnt_cyc_log[2], 8);
      end
      drain(20, "t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
